bit_serial_adder: RTL and testbench

//  Operand-sequencing stage that feeds the 1-bit conditional_sum_adder cell: accepts two WIDTH-bit

---
 rtl/bit_serial_adder_pkg.sv | 17 +
 rtl/bit_serial_adder_csa.sv | 26 ++
 rtl/bit_serial_adder.sv | 131 +++++++++++++
 tb/tb_bit_serial_adder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and counter sizing.
package bit_serial_adder_pkg;

  // Encoding 2'd3 is never entered; the top decodes it as idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_RSVD = 2'd3
  } state_t;

  // Bit counter width: enough to hold WIDTH-1, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/bit_serial_adder_csa.sv
// One-bit conditional-sum cell: both sum/carry candidates are formed up front
// and the incoming carry only drives the final select.
module conditional_sum_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  logic sum_c0;
  logic sum_c1;
  logic co_c0;
  logic co_c1;

  // Candidate results for carry 0 / carry 1, then carry-driven selection.
  always_comb begin
    sum_c0    = a ^ b;
    sum_c1    = ~(a ^ b);
    co_c0     = a & b;
    co_c1     = a | b;
    sum       = carry_in ? sum_c1 : sum_c0;
    carry_out = carry_in ? co_c1  : co_c0;
  end

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial unsigned adder: captures two WIDTH-bit operands and a carry,
// feeds them LSB-first through a one-bit cell with a registered carry loop,
// and returns the WIDTH-bit sum plus final carry through a valid/ready port.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  if (WIDTH < 1) begin : g_width_check
    $error("bit_serial_adder: WIDTH must be >= 1");
  end

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  state_t           state_cur;
  logic [CNT_W-1:0] cnt;
  logic             c_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;
  logic             accept;
  logic             cell_sum;
  logic             cell_co;

  conditional_sum_adder u_cell (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .carry_in  (c_q),
    .sum       (cell_sum),
    .carry_out (cell_co)
  );

  // Decode the state register (unused code maps to idle), derive next state and handshake flags.
  always_comb begin
    state_cur = ST_IDLE;
    state_d   = ST_IDLE;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    if (state_q == ST_RUN || state_q == ST_DONE) begin
      state_cur = state_q;
    end
    last_bit = (cnt == CNT_LAST);
    accept   = 1'b0;
    case (state_cur)
      ST_RUN: begin
        busy    = 1'b1;
        state_d = last_bit ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        state_d   = out_ready ? ST_IDLE : ST_DONE;
      end
      default: begin
        in_ready = 1'b1;
        accept   = in_valid;
        state_d  = in_valid ? ST_RUN : ST_IDLE;
      end
    endcase
  end

  // Next value of the result shift register: new sum bit enters at the MSB.
  always_comb begin
    res_next           = res_sr >> 1;
    res_next[WIDTH-1]  = cell_sum;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control-side registers: bit counter, carry loop and the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      c_q       <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      c_q <= carry_in;
    end else if (state_cur == ST_RUN) begin
      c_q <= cell_co;
      if (last_bit) begin
        cnt       <= '0;
        sum       <= res_next;
        carry_out <= cell_co;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Operand and result shift registers; contents are only meaningful during RUN.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sr <= a;
      b_sr <= b;
    end else if (state_cur == ST_RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next;
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed checks on an 8-bit
// instance, then scoreboarded random traffic on 8-, 1- and 13-bit instances.
module tb_bit_serial_adder;

  logic        clk;
  logic        rst;
  logic        iv   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic        cin  [3];
  logic        co   [3];
  logic        bz   [3];
  logic [15:0] a_v  [3];
  logic [15:0] b_v  [3];
  logic [15:0] s_v  [3];
  logic [7:0]  sum8;
  logic [0:0]  sum1;
  logic [12:0] sum13;

  int wids [3] = '{8, 1, 13};
  int n_cmp = 0;
  int n_err = 0;
  int cur   = 0;
  bit sb_en = 1'b0;
  longint exp_q [$];

  bit_serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
    .carry_in(cin[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum8), .carry_out(co[0]), .busy(bz[0])
  );
  bit_serial_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_v[1][0:0]), .b(b_v[1][0:0]),
    .carry_in(cin[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum1), .carry_out(co[1]), .busy(bz[1])
  );
  bit_serial_adder #(.WIDTH(13)) u_w13 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_v[2][12:0]), .b(b_v[2][12:0]),
    .carry_in(cin[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum13), .carry_out(co[2]), .busy(bz[2])
  );

  always_comb begin
    s_v[0] = {8'd0, sum8};
    s_v[1] = {15'd0, sum1};
    s_v[2] = {3'd0, sum13};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model: a + b + cin over w bits, carry in bit w.
  function automatic longint ref_add(input logic [15:0] av, input logic [15:0] bv, input logic c, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (longint'(av) & m) + (longint'(bv) & m) + longint'(c);
  endfunction

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge clk) begin
    if (sb_en) begin
      if (ov[cur] && ordy[cur]) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_output", 1, 0);
        end else begin
          chk("sb_result", (longint'(co[cur]) << wids[cur]) | longint'(s_v[cur]), exp_q.pop_front());
        end
      end
      if (iv[cur] && ir[cur]) begin
        exp_q.push_back(ref_add(a_v[cur], b_v[cur], cin[cur], wids[cur]));
      end
    end
  end

  // Directed helpers on the 8-bit instance.
  task automatic go8(input logic [7:0] av, input logic [7:0] bv, input logic c);
    iv[0]  = 1'b1;
    a_v[0] = {8'd0, av};
    b_v[0] = {8'd0, bv};
    cin[0] = c;
    @(posedge clk);
    #1 iv[0] = 1'b0;
  endtask

  task automatic wait_out8(output int n);
    n = 0;
    while (!ov[0] && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic release8();
    ordy[0] = 1'b1;
    @(posedge clk);
    #1 ordy[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic new_operands(input int id);
    a_v[id] = 16'($urandom);
    b_v[id] = 16'($urandom);
    cin[id] = 1'($urandom);
  endtask

  task automatic run_rand(input int id, input int nops);
    int  w;
    int  cyc;
    int  prev;
    int  nacc;
    int  limit;
    bit  acc;
    w     = wids[id];
    cur   = id;
    sb_en = 1'b1;
    // Back-to-back phase: both handshakes held high.
    iv[id] = 1'b1;
    ordy[id] = 1'b1;
    new_operands(id);
    cyc = 0; prev = -1; nacc = 0;
    while (nacc < 6 && cyc < 200) begin
      @(negedge clk);
      acc = iv[id] && ir[id];
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        if (prev >= 0) chk($sformatf("throughput_w%0d", w), cyc - prev, w + 2);
        prev = cyc;
        nacc++;
        new_operands(id);
      end
    end
    chk($sformatf("throughput_accepts_w%0d", w), nacc, 6);
    // Random handshake phase.
    nacc  = 0;
    cyc   = 0;
    limit = nops * (w + 2) * 4;
    while (nacc < nops && cyc < limit) begin
      iv[id]   = ($urandom_range(0, 3) != 0);
      ordy[id] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = iv[id] && ir[id];
      @(posedge clk);
      #1;
      cyc++;
      if (acc) nacc++;
      new_operands(id);
    end
    chk($sformatf("random_accepts_w%0d", w), nacc, nops);
    iv[id]   = 1'b0;
    ordy[id] = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    @(negedge clk);
    chk($sformatf("drain_w%0d", w), exp_q.size(), 0);
    ordy[id] = 1'b0;
    sb_en    = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; cin[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", ir[0], 1);
    chk("reset_out_valid", ov[0], 0);
    chk("reset_busy", bz[0], 0);
    chk("reset_sum", sum8, 0);
    chk("reset_carry", co[0], 0);

    // FF + 01 + 0: latency and wrap.
    go8(8'hFF, 8'h01, 1'b0);
    wait_out8(n);
    chk("latency_w8", n, 8);
    chk("ff01_sum", sum8, 8'h00);
    chk("ff01_carry", co[0], 1);
    release8();

    // 5A + A5 with both carry values.
    go8(8'h5A, 8'hA5, 1'b1);
    wait_out8(n);
    chk("5aa5c1_sum", sum8, 8'h00);
    chk("5aa5c1_carry", co[0], 1);
    release8();
    go8(8'h5A, 8'hA5, 1'b0);
    wait_out8(n);
    chk("5aa5c0_sum", sum8, 8'hFF);
    chk("5aa5c0_carry", co[0], 0);
    release8();

    // Backpressure: result held while out_ready stays low.
    go8(8'h12, 8'h34, 1'b0);
    wait_out8(n);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_sum", sum8, 8'h46);
      chk("bp_carry", co[0], 0);
      chk("bp_in_ready", ir[0], 0);
      chk("bp_out_valid", ov[0], 1);
    end
    release8();
    chk("handoff_in_ready", ir[0], 1);
    chk("handoff_out_valid", ov[0], 0);
    chk("handoff_sum_kept", sum8, 8'h46);

    // Reset while the counter sits at 3.
    go8(8'h11, 8'h22, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", ov[0], 0);
    chk("abort_in_ready", ir[0], 1);
    chk("abort_sum", sum8, 0);
    chk("abort_busy", bz[0], 0);
    go8(8'h03, 8'h04, 1'b0);
    wait_out8(n);
    chk("after_abort_sum", sum8, 8'h07);
    chk("after_abort_carry", co[0], 0);
    release8();

    // Operand changes and in_valid during RUN are ignored.
    go8(8'h10, 8'h20, 1'b1);
    for (int k = 0; k < 5; k++) begin
      iv[0]  = k[0];
      a_v[0] = 16'($urandom);
      b_v[0] = 16'($urandom);
      cin[0] = 1'($urandom);
      @(negedge clk);
      chk("run_in_ready", ir[0], 0);
      @(posedge clk);
      #1;
    end
    iv[0] = 1'b0;
    wait_out8(n);
    chk("ignore_sum", sum8, 8'h31);
    chk("ignore_carry", co[0], 0);
    release8();

    run_rand(0, 1000);
    run_rand(1, 1000);
    run_rand(2, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
